// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC register and fetch counter for the single-cycle
// CPU. It advances the PC by 4, by a relative branch or to an absolute jump
// target, but only on a fetch accepted by instruction memory. It holds the PC
// while stalled and stops for good on a halt or on a misaligned redirect.
module pc_sequencer #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0040_0000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             run_en,
    input  logic             stall,
    input  logic             halt_req,
    input  logic             ir_ready,
    input  logic             jmp,
    input  logic [WIDTH-1:0] jmp_target,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_offset,
    output logic             fetch_valid,
    output logic [WIDTH-1:0] fetch_addr,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] NPC,
    output logic [1:0]       state,
    output logic [WIDTH-1:0] fetch_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t           cur_state;
    state_t           next_state;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] target;
    logic             advance;
    logic             redirect;
    logic             misaligned;

    // Sequential PC is always visible; carries past the top bit are dropped.
    assign NPC        = PC + WIDTH'(4);
    assign fetch_addr = PC;
    assign state      = cur_state;

    // Next-state, fetch request and next PC/count selection.
    always_comb begin
        next_state  = cur_state;
        pc_next     = PC;
        count_next  = fetch_count;
        fetch_valid = 1'b0;
        advance     = 1'b0;
        redirect    = jmp | br_taken;
        // jmp outranks a simultaneous branch.
        target      = jmp ? jmp_target : (NPC + br_offset);
        misaligned  = redirect && (target[1:0] != 2'b00);

        case (cur_state)
            IDLE: begin
                if (run_en) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                // A halt request suppresses the fetch, so it always wins over ir_ready.
                fetch_valid = !stall && !halt_req;
                advance     = fetch_valid && ir_ready;
                if (halt_req) begin
                    next_state = HALT;
                end else if (advance) begin
                    if (misaligned) begin
                        // PC and count stay put so the faulting PC is preserved.
                        next_state = ERR;
                    end else begin
                        pc_next    = redirect ? target : NPC;
                        count_next = fetch_count + WIDTH'(1);
                    end
                end
            end
            default: begin
                // HALT and ERR are terminal until reset.
                next_state = cur_state;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    // PC and accepted-fetch counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            PC          <= RESET_PC;
            fetch_count <= '0;
        end else begin
            PC          <= pc_next;
            fetch_count <= count_next;
        end
    end

endmodule
